bram_sdp_clr: RTL and testbench

- Parametrised simple-dual-port block RAM; successor to the fixed 2^18 x 8b single-port frame buffer used by the median-filter datapath.
- Port A writes and port B reads in the same cycle. Read-during-write mode and output register are selectable.
- Built-in sequential clear engine overwrites the whole array with a constant between frames, with no software loop.

---
 rtl/bram_sdp_clr.sv | 154 +++++++++++++++
 tb/tb_bram_sdp_clr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_clr.sv
// Simple-dual-port block RAM (port A write, port B read) with a sequential clear engine
// muxed onto the write port. Define BRAM_PARITY_EN to store and check even parity per word.
//
// state | meaning
// IDLE  | user writes and reads accepted, clr_start honoured
// CLEAR | CLR_VALUE written to mem[cnt] every cycle, user traffic dropped
module bram_sdp_clr #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 18,
    parameter int                    RDW_MODE   = 0,
    parameter int                    OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  doutb_valid,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done
`ifdef BRAM_PARITY_EN
    ,
    input  logic                  par_inj,
    output logic                  par_err
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef BRAM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
`else
    localparam int MW = DATA_WIDTH;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   s1_q, s1_d, s2_q, s2_d;
    logic                    v1_q, v1_d, v2_q, v2_d;

    logic [MW-1:0]           mem [DEPTH];
    logic                    user_wr, rd_en, we;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [MW-1:0]           wword, rword;

`ifdef BRAM_PARITY_EN
    logic                    p1_q, p1_d, p2_q, p2_d;
`endif

    always_comb begin
        user_wr = (state_q == IDLE) && ena && wea;
        rd_en   = (state_q == IDLE) && enb;
        // rst must suppress the write of the cycle it lands in so an aborted clear stops cleanly
        we      = !rst && (user_wr || (state_q == CLEAR));
        waddr   = (state_q == CLEAR) ? cnt_q : addra;
        wdata   = (state_q == CLEAR) ? CLR_VALUE : dina;
`ifdef BRAM_PARITY_EN
        wword   = {(^wdata) ^ (user_wr & par_inj), wdata};
`else
        wword   = wdata;
`endif
        rword   = mem[addrb];
        if ((RDW_MODE != 0) && user_wr && (addra == addrb)) begin
            rword = wword;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        v1_d = rd_en;
        s1_d = rd_en ? rword[DATA_WIDTH-1:0] : s1_q;
        v2_d = v1_q;
        s2_d = v1_q ? s1_q : s2_q;
`ifdef BRAM_PARITY_EN
        p1_d = rd_en && (^rword);
        p2_d = p1_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wword;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s1_q    <= '0;
            s2_q    <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
`ifdef BRAM_PARITY_EN
            p1_q    <= 1'b0;
            p2_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
`ifdef BRAM_PARITY_EN
            p1_q    <= p1_d;
            p2_q    <= p2_d;
`endif
        end
    end

    assign doutb       = (OUT_REG != 0) ? s2_q : s1_q;
    assign doutb_valid = (OUT_REG != 0) ? v2_q : v1_q;
    assign clr_busy    = busy_q;
    assign clr_done    = done_q;
`ifdef BRAM_PARITY_EN
    assign par_err     = (OUT_REG != 0) ? p2_q : p1_q;
`endif

endmodule

// File: tb/tb_bram_sdp_clr.sv
// Bench for bram_sdp_clr: two instances (read-first/no out reg, write-first/out reg) share
// one directed stimulus; a behavioural model feeds per-instance scoreboard queues.
module tb_bram_sdp_clr;
    localparam int          DW    = 8;
    localparam int          AW    = 4;
    localparam logic [7:0]  CLRV  = 8'h3C;
`ifdef BRAM_PARITY_EN
    localparam bit          PAR_EN = 1'b1;
`else
    localparam bit          PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, ena = 1'b0, wea = 1'b0, enb = 1'b0, clr_start = 1'b0;
    logic          par_inj = 1'b0;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [DW-1:0] dina = '0;
    logic [DW-1:0] doutb0, doutb1;
    logic          v0, v1, busy0, busy1, done0, done1;
`ifdef BRAM_PARITY_EN
    logic          pe0, pe1;
`endif

    bram_sdp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(0), .OUT_REG(0), .CLR_VALUE(CLRV)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb0), .doutb_valid(v0),
        .clr_start(clr_start), .clr_busy(busy0), .clr_done(done0)
`ifdef BRAM_PARITY_EN
        , .par_inj(par_inj), .par_err(pe0)
`endif
    );

    bram_sdp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(1), .OUT_REG(1), .CLR_VALUE(CLRV)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(doutb1), .doutb_valid(v1),
        .clr_start(clr_start), .clr_busy(busy1), .clr_done(done1)
`ifdef BRAM_PARITY_EN
        , .par_inj(par_inj), .par_err(pe1)
`endif
    );

    // model state
    logic [7:0] m_mem [16];
    logic       m_pf  [16];
    logic       m_clr = 1'b0;
    logic [3:0] m_cnt = '0;
    logic       m_busy = 1'b0, m_done = 1'b0;
    logic       m_ev0 = 1'b0, m_s1v = 1'b0, m_ev1 = 1'b0;
    logic [7:0] m_dout0 = '0, m_dout1 = '0;
    logic       m_pe0 = 1'b0, m_pe1 = 1'b0;
    logic [8:0] q0[$], q1[$];
    logic [8:0] mon_e;

    int  n_checks = 0, n_fail = 0;
    int  busy_cnt = 0, done_cnt = 0;
    bit  chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic       acc, inj;
        logic [8:0] e0, e1;
        inj = PAR_EN & par_inj;
        acc = enb && !m_clr;
        if (rst) begin
            m_clr = 1'b0; m_cnt = '0; m_busy = 1'b0; m_done = 1'b0;
            m_ev0 = 1'b0; m_s1v = 1'b0; m_ev1 = 1'b0;
            m_dout0 = '0; m_dout1 = '0;
            q0.delete(); q1.delete();
        end else begin
            m_ev1 = m_s1v;
            m_s1v = acc;
            m_ev0 = acc;
            if (acc) begin
                e0 = {m_pf[addrb], m_mem[addrb]};
                e1 = (ena && wea && (addra == addrb)) ? {inj, dina} : e0;
                q0.push_back(e0);
                q1.push_back(e1);
            end
            m_done = 1'b0;
            if (!m_clr) begin
                if (ena && wea) begin
                    m_mem[addra] = dina;
                    m_pf[addra]  = inj;
                end
                if (clr_start) begin
                    m_clr = 1'b1; m_cnt = '0; m_busy = 1'b1;
                end
            end else begin
                m_mem[m_cnt] = CLRV;
                m_pf[m_cnt]  = 1'b0;
                if (m_cnt == 4'hF) begin
                    m_clr = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_cnt = '0;
                end else begin
                    m_cnt = m_cnt + 4'd1;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic inj);
        ena = 1'b1; wea = 1'b1; addra = a; dina = d; par_inj = inj;
        step();
        ena = 1'b0; wea = 1'b0; par_inj = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        enb = 1'b1; addrb = a;
        step();
        enb = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            enb = 1'b1; addrb = 4'(i);
            step();
        end
        enb = 1'b0;
        idle(3);
    endtask

    // output monitor: pops the scoreboard whenever the model expects a valid word
    always @(negedge clk) begin
        if (chk_en) begin
            if (m_ev0) begin
                chk("q0_has_entry", 32'(q0.size() != 0), 32'd1);
                if (q0.size() != 0) begin
                    mon_e = q0.pop_front();
                    m_dout0 = mon_e[7:0]; m_pe0 = mon_e[8];
                end
            end else m_pe0 = 1'b0;
            if (m_ev1) begin
                chk("q1_has_entry", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    mon_e = q1.pop_front();
                    m_dout1 = mon_e[7:0]; m_pe1 = mon_e[8];
                end
            end else m_pe1 = 1'b0;
            chk("valid_rf", 32'(v0), 32'(m_ev0));
            chk("dout_rf", 32'(doutb0), 32'(m_dout0));
            chk("valid_wf_reg", 32'(v1), 32'(m_ev1));
            chk("dout_wf_reg", 32'(doutb1), 32'(m_dout1));
            chk("busy_rf", 32'(busy0), 32'(m_busy));
            chk("busy_wf", 32'(busy1), 32'(m_busy));
            chk("done_rf", 32'(done0), 32'(m_done));
            chk("done_wf", 32'(done1), 32'(m_done));
`ifdef BRAM_PARITY_EN
            chk("par_err_rf", 32'(pe0), 32'(m_ev0 & m_pe0));
            chk("par_err_wf", 32'(pe1), 32'(m_ev1 & m_pe1));
`endif
            if (busy0) busy_cnt++;
            if (done0) done_cnt++;
        end
    end

    initial begin
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        idle(1);

        // basic write then read
        wr(4'd3, 8'hA5, 1'b0);
        rd(4'd3);
        idle(3);

        // same-address collision, then plain re-read
        wr(4'd5, 8'h11, 1'b0);
        ena = 1'b1; wea = 1'b1; addra = 4'd5; dina = 8'h22; enb = 1'b1; addrb = 4'd5;
        step();
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        rd(4'd5);
        idle(3);

        // different addresses in the same cycle
        ena = 1'b1; wea = 1'b1; addra = 4'd7; dina = 8'h5A; enb = 1'b1; addrb = 4'd3;
        step();
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        rd(4'd7);
        idle(3);

        // reset flushes an in-flight read
        rd(4'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(3);

        // full clear with user traffic and a second clr_start during busy
        for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            ena = 1'b1; wea = 1'b1; addra = 4'(i); dina = 8'h55;
            enb = 1'b1; addrb = 4'(i); clr_start = (i == 8);
            step();
        end
        ena = 1'b0; wea = 1'b0; enb = 1'b0; clr_start = 1'b0;
        idle(3);
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("clr_done_pulses", 32'(done_cnt), 32'd1);
        read_all();

        // clear started together with a write, aborted by rst on the 6th busy cycle
        for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF, 1'b0);
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1; ena = 1'b1; wea = 1'b1; addra = 4'd12; dina = 8'h77;
        step();
        clr_start = 1'b0; ena = 1'b0; wea = 1'b0;
        idle(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(2);
        chk("abort_busy_cycles", 32'(busy_cnt), 32'd6);
        chk("abort_done_pulses", 32'(done_cnt), 32'd0);
        read_all();

        // parity injection, then clear restores clean parity
        wr(4'd2, 8'h07, 1'b1);
        wr(4'd6, 8'h07, 1'b0);
        rd(4'd2);
        rd(4'd6);
        idle(3);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        idle(18);
        rd(4'd2);
        rd(4'd6);
        idle(3);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
